// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter for the 256x16 data memory, shared by the CPU port and the HOST port.
// Latency: grant and memory fields are registered one edge after the request; read data arrives one cycle after the grant.
// Backpressure: a requester that loses holds Req/Addr/Wr/WData. HOST lock is bounded, so CPU waits at most MAX_LOCK+1 cycles.
module dmem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int MAX_LOCK = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              CpuReq,
   input  logic              CpuWr,
   input  logic [ADDR_W-1:0] CpuAddr,
   input  logic [DATA_W-1:0] CpuWData,
   output logic              CpuGnt,
   output logic              CpuRValid,
   input  logic              HostReq,
   input  logic              HostWr,
   input  logic              HostLock,
   input  logic [ADDR_W-1:0] HostAddr,
   input  logic [DATA_W-1:0] HostWData,
   output logic              HostGnt,
   output logic              HostRValid,
   output logic [DATA_W-1:0] RData,
   output logic [ADDR_W-1:0] D_addr,
   output logic              D_wr,
   output logic [DATA_W-1:0] D_wdata,
   input  logic [DATA_W-1:0] D_rdata,
   output logic [1:0]        ArbState
);

   localparam int LOCK_W = $clog2(MAX_LOCK + 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CPU  = 2'b01,
      ST_HOST = 2'b10
   } arb_state_t;

   arb_state_t        state_q, state_d;
   logic              last_host_q, last_host_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic              cpu_rvalid_q, host_rvalid_q;

   // Choose the next owner, and update the round-robin pointer and the host lock counter.
   always_comb begin
      state_d     = ST_IDLE;
      last_host_d = last_host_q;
      lock_cnt_d  = '0;

      if (CpuReq && HostReq) begin
         // The host keeps ownership only while it is already the owner and its lock budget is not used up.
         if (state_q == ST_HOST && HostLock && lock_cnt_q < LOCK_MAX)
            state_d = ST_HOST;
         else if (last_host_q)
            state_d = ST_CPU;
         else
            state_d = ST_HOST;
      end else if (CpuReq) begin
         state_d = ST_CPU;
      end else if (HostReq) begin
         state_d = ST_HOST;
      end

      // The pointer survives IDLE cycles, so fairness carries across gaps in traffic.
      if (state_d == ST_HOST)
         last_host_d = 1'b1;
      else if (state_d == ST_CPU)
         last_host_d = 1'b0;

      if (state_d == ST_HOST && HostLock) begin
         if (state_q != ST_HOST)
            lock_cnt_d = LOCK_W'(1);
         else if (lock_cnt_q >= LOCK_MAX)
            lock_cnt_d = LOCK_MAX;
         else
            lock_cnt_d = lock_cnt_q + 1'b1;
      end
   end

   // Arbitration state. After reset the pointer says HOST, so the CPU wins the first tie.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         last_host_q <= 1'b1;
         lock_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_host_q <= last_host_d;
         lock_cnt_q  <= lock_cnt_d;
      end
   end

   // Register the winner's access. Address and data hold while idle; the write enable is dropped.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         D_addr  <= '0;
         D_wr    <= 1'b0;
         D_wdata <= '0;
      end else begin
         case (state_d)
            ST_CPU: begin
               D_addr  <= CpuAddr;
               D_wr    <= CpuWr;
               D_wdata <= CpuWData;
            end
            ST_HOST: begin
               D_addr  <= HostAddr;
               D_wr    <= HostWr;
               D_wdata <= HostWData;
            end
            default: D_wr <= 1'b0;
         endcase
      end
   end

   // Flag read data to the port that issued a read in the previous cycle. Reset kills any read in flight.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
      end else begin
         cpu_rvalid_q  <= (state_q == ST_CPU)  && !D_wr;
         host_rvalid_q <= (state_q == ST_HOST) && !D_wr;
      end
   end

   assign CpuGnt     = (state_q == ST_CPU);
   assign HostGnt    = (state_q == ST_HOST);
   assign CpuRValid  = cpu_rvalid_q;
   assign HostRValid = host_rvalid_q;
   assign RData      = D_rdata;
   assign ArbState   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a table of per-cycle request/grant vectors, plus hand-written reset sequences.
// A behavioural 256x16 synchronous memory sits on the D_* port.
// Expected read data is queued when a read grant is scheduled and popped when RValid appears.
module tb_dmem_arbiter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        CpuReq = 1'b0, CpuWr = 1'b0, HostReq = 1'b0, HostWr = 1'b0, HostLock = 1'b0;
   logic [7:0]  CpuAddr = '0, HostAddr = '0;
   logic [15:0] CpuWData = '0, HostWData = '0;
   logic        CpuGnt, CpuRValid, HostGnt, HostRValid, D_wr;
   logic [15:0] RData, D_wdata, D_rdata;
   logic [7:0]  D_addr;
   logic [1:0]  ArbState;

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .CpuReq(CpuReq), .CpuWr(CpuWr), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
      .CpuGnt(CpuGnt), .CpuRValid(CpuRValid),
      .HostReq(HostReq), .HostWr(HostWr), .HostLock(HostLock), .HostAddr(HostAddr),
      .HostWData(HostWData), .HostGnt(HostGnt), .HostRValid(HostRValid),
      .RData(RData), .D_addr(D_addr), .D_wr(D_wr), .D_wdata(D_wdata),
      .D_rdata(D_rdata), .ArbState(ArbState)
   );

   always #5 Clk = ~Clk;

   // Memory model: the write lands at the grant-cycle edge; read data appears in the cycle after the address.
   logic [15:0] mem [256];
   logic [15:0] mem_q = '0;
   always @(posedge Clk) begin
      if (D_wr) mem[D_addr] <= D_wdata;
      mem_q <= mem[D_addr];
   end
   assign D_rdata = mem_q;

   typedef struct {
      logic        creq, cwr;
      logic [7:0]  caddr;
      logic [15:0] cwd;
      logic        hreq, hwr, hlock;
      logic [7:0]  haddr;
      logic [15:0] hwd;
      logic [1:0]  st;
      logic        cg, hg, dwr;
      logic [7:0]  daddr;
      logic [15:0] dwd;
      logic        crv, hrv;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] sb[$];
   logic [15:0] ref_mem [256];

   function automatic vec_t mk(logic creq, logic cwr, logic [7:0] caddr, logic [15:0] cwd,
                               logic hreq, logic hwr, logic hlock, logic [7:0] haddr, logic [15:0] hwd,
                               logic [1:0] st, logic cg, logic hg, logic dwr, logic [7:0] daddr,
                               logic [15:0] dwd, logic crv, logic hrv);
      vec_t v;
      v.creq = creq; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
      v.hreq = hreq; v.hwr = hwr; v.hlock = hlock; v.haddr = haddr; v.hwd = hwd;
      v.st = st; v.cg = cg; v.hg = hg; v.dwr = dwr; v.daddr = daddr; v.dwd = dwd;
      v.crv = crv; v.hrv = hrv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      CpuReq = 0; CpuWr = 0; CpuAddr = '0; CpuWData = '0;
      HostReq = 0; HostWr = 0; HostLock = 0; HostAddr = '0; HostWData = '0;
   endtask

   // Advance one edge and sample 1 ns later. Any RValid is matched against the scoreboard.
   task automatic step();
      @(posedge Clk);
      #1;
      if (CpuRValid || HostRValid) begin
         if (sb.size() == 0) begin
            chk("rvalid_unexpected", 32'(CpuRValid) << 1 | 32'(HostRValid), 32'd0);
         end else begin
            chk("rdata", 32'(RData), 32'(sb.pop_front()));
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cgnt"},  32'(CpuGnt), 0);
      chk({tag, "_hgnt"},  32'(HostGnt), 0);
      chk({tag, "_crv"},   32'(CpuRValid), 0);
      chk({tag, "_hrv"},   32'(HostRValid), 0);
      chk({tag, "_dwr"},   32'(D_wr), 0);
      chk({tag, "_daddr"}, 32'(D_addr), 0);
      chk({tag, "_dwd"},   32'(D_wdata), 0);
      chk({tag, "_state"}, 32'(ArbState), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end

      // Reset low with random inputs: the outputs must stay at their reset values.
      #1 Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         CpuReq = 1'($urandom); CpuWr = 1'($urandom); CpuAddr = 8'($urandom); CpuWData = 16'($urandom);
         HostReq = 1'($urandom); HostWr = 1'($urandom); HostLock = 1'($urandom);
         HostAddr = 8'($urandom); HostWData = 16'($urandom);
         step();
      end
      chk_reset_vals("rst");
      drive_idle();
      Reset = 1'b1;

      //          creq cwr caddr  cwd       hreq hwr hlk haddr  hwd      | st cg hg dwr daddr  dwd      crv hrv
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h00,16'h0000,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h00,16'h0000,0,0));
      vecs.push_back(mk(1,1,8'h10,16'h1234, 0,0,0,8'h00,16'h0000, 2'd1,1,0,1,8'h10,16'h1234,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h10,16'h1234,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 1,0,0,8'h10,16'hBEEF, 2'd2,0,1,0,8'h10,16'hBEEF,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h10,16'hBEEF,0,1));
      // Plain round-robin under contention.
      for (int i = 0; i < 3; i++) begin
         vecs.push_back(mk(1,1,8'h20,16'hAAAA, 1,1,0,8'h21,16'h5555, 2'd1,1,0,1,8'h20,16'hAAAA,0,0));
         vecs.push_back(mk(1,1,8'h20,16'hAAAA, 1,1,0,8'h21,16'h5555, 2'd2,0,1,1,8'h21,16'h5555,0,0));
      end
      // CPU write followed by a HOST read of the same word in the next cycle returns the new data.
      vecs.push_back(mk(1,1,8'h30,16'h1111, 1,0,0,8'h30,16'h0000, 2'd1,1,0,1,8'h30,16'h1111,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 1,0,0,8'h30,16'h0000, 2'd2,0,1,0,8'h30,16'h0000,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h30,16'h0000,0,1));
      vecs.push_back(mk(1,0,8'h21,16'h0000, 0,0,0,8'h00,16'h0000, 2'd1,1,0,0,8'h21,16'h0000,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h21,16'h0000,1,0));
      // Host lock: one CPU grant, then H x4, C, H, a locked H, and an unlocked tie that goes to C.
      vecs.push_back(mk(1,1,8'h40,16'h0003, 0,0,0,8'h00,16'h0000, 2'd1,1,0,1,8'h40,16'h0003,0,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1,1,8'h40,16'h0003, 1,1,1,8'h41,16'h0002, 2'd2,0,1,1,8'h41,16'h0002,0,0));
      vecs.push_back(mk(1,1,8'h40,16'h0003, 1,1,1,8'h41,16'h0002, 2'd1,1,0,1,8'h40,16'h0003,0,0));
      vecs.push_back(mk(1,1,8'h40,16'h0003, 1,1,1,8'h41,16'h0002, 2'd2,0,1,1,8'h41,16'h0002,0,0));
      vecs.push_back(mk(1,1,8'h40,16'h0003, 1,1,1,8'h41,16'h0002, 2'd2,0,1,1,8'h41,16'h0002,0,0));
      vecs.push_back(mk(1,1,8'h40,16'h0003, 1,1,0,8'h41,16'h0002, 2'd1,1,0,1,8'h40,16'h0003,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h40,16'h0003,0,0));
      // A long uncontended locked host burst saturates the counter, so the next tie still goes to the CPU.
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,1,8'h60,16'h00F0, 2'd2,0,1,1,8'h60,16'h00F0,0,0));
      vecs.push_back(mk(1,1,8'h40,16'h0003, 1,1,1,8'h60,16'h00F0, 2'd1,1,0,1,8'h40,16'h0003,0,0));
      vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 2'd0,0,0,0,8'h40,16'h0003,0,0));

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         CpuReq = v.creq; CpuWr = v.cwr; CpuAddr = v.caddr; CpuWData = v.cwd;
         HostReq = v.hreq; HostWr = v.hwr; HostLock = v.hlock; HostAddr = v.haddr; HostWData = v.hwd;
         if (v.cg || v.hg) begin
            if (v.dwr) ref_mem[v.daddr] = v.dwd;
            else       sb.push_back(ref_mem[v.daddr]);
         end
         step();
         chk($sformatf("v%0d_state", i), 32'(ArbState), 32'(v.st));
         chk($sformatf("v%0d_cgnt", i),  32'(CpuGnt), 32'(v.cg));
         chk($sformatf("v%0d_hgnt", i),  32'(HostGnt), 32'(v.hg));
         chk($sformatf("v%0d_dwr", i),   32'(D_wr), 32'(v.dwr));
         chk($sformatf("v%0d_daddr", i), 32'(D_addr), 32'(v.daddr));
         chk($sformatf("v%0d_dwd", i),   32'(D_wdata), 32'(v.dwd));
         chk($sformatf("v%0d_crv", i),   32'(CpuRValid), 32'(v.crv));
         chk($sformatf("v%0d_hrv", i),   32'(HostRValid), 32'(v.hrv));
      end
      drive_idle();
      chk("sb_drained", 32'(sb.size()), 0);

      // Reset pulse in the middle of a host read grant: the read data valid must never appear.
      HostReq = 1; HostWr = 0; HostAddr = 8'h10;
      step();
      chk("rp_hgnt", 32'(HostGnt), 1);
      Reset = 1'b0;
      drive_idle();
      #1;
      chk_reset_vals("rp");
      #2 Reset = 1'b1;
      step();
      chk("rp_hrv1", 32'(HostRValid), 0);
      step();
      chk("rp_hrv2", 32'(HostRValid), 0);

      // The round-robin pointer returns to HOST on reset, even when the CPU was the last winner.
      CpuReq = 1; CpuWr = 1; CpuAddr = 8'h50; CpuWData = 16'h7777;
      step();
      chk("rp2_cgnt", 32'(CpuGnt), 1);
      Reset = 1'b0;
      drive_idle();
      #2 Reset = 1'b1;
      CpuReq = 1; CpuWr = 1; CpuAddr = 8'h51; CpuWData = 16'h0101;
      HostReq = 1; HostWr = 1; HostAddr = 8'h52; HostWData = 16'h0202;
      step();
      chk("tie_cgnt", 32'(CpuGnt), 1);
      chk("tie_hgnt", 32'(HostGnt), 0);
      chk("tie_daddr", 32'(D_addr), 32'h51);
      drive_idle();
      step();
      chk("end_state", 32'(ArbState), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
